excp_commit_ctrl: RTL and testbench

- Writeback-stage commit controller that sequences every exception, interrupt and ertn event into the CSR file.
- Selects one event per committing instruction by fixed priority and drives the CSR exception/ertn update pulses for exactly one cycle.
- Flushes the pipeline and issues a PC redirect to fetch with a valid/ready handshake.
- Sits between the WB stage, the csr block and the IF-stage PC logic.

---
 rtl/excp_commit_ctrl_if.sv | 40 ++++
 rtl/excp_commit_ctrl.sv | 168 ++++++++++++++++
 tb/tb_excp_commit_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/excp_commit_ctrl_if.sv
// Commit-stage bundle: WB commit handshake, CSR exception/ertn update and the IF redirect.
// The slave side belongs to the commit controller; the master side is its environment.
interface excp_commit_ctrl_if #(
  parameter int COUNT_W = 16
);
  logic               wb_valid;
  logic [31:0]        wb_inst_pc;
  logic [4:0]         wb_excp_vec;
  logic [31:0]        wb_vaddr_in;
  logic               wb_ertn;
  logic               wb_ready;
  logic               interrupt;
  logic [31:0]        exception_entry;
  logic [31:0]        exception_return_entry;
  logic               wb_exception;
  logic [5:0]         wb_ecode;
  logic [8:0]         wb_esubcode;
  logic [31:0]        wb_pc;
  logic [31:0]        wb_vaddr;
  logic               ertn_flush;
  logic               pipe_flush;
  logic               redirect_valid;
  logic [31:0]        redirect_pc;
  logic               redirect_ready;
  logic [COUNT_W-1:0] event_count;

  modport slave (
    input  wb_valid, wb_inst_pc, wb_excp_vec, wb_vaddr_in, wb_ertn,
    input  interrupt, exception_entry, exception_return_entry, redirect_ready,
    output wb_ready, wb_exception, wb_ecode, wb_esubcode, wb_pc, wb_vaddr,
    output ertn_flush, pipe_flush, redirect_valid, redirect_pc, event_count
  );

  modport master (
    output wb_valid, wb_inst_pc, wb_excp_vec, wb_vaddr_in, wb_ertn,
    output interrupt, exception_entry, exception_return_entry, redirect_ready,
    input  wb_ready, wb_exception, wb_ecode, wb_esubcode, wb_pc, wb_vaddr,
    input  ertn_flush, pipe_flush, redirect_valid, redirect_pc, event_count
  );
endinterface

// File: rtl/excp_commit_ctrl.sv
// Writeback commit controller: picks one exception/interrupt/ertn per instruction,
// pulses the CSR update, flushes the pipe and hands a redirect target to fetch.
module excp_commit_ctrl #(
  parameter int HOLDOFF = 2,
  parameter int COUNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  excp_commit_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COMMIT   = 2'd1,
    REDIRECT = 2'd2,
    HOLD     = 2'd3
  } state_t;

  localparam logic [3:0] HOLD_LAST = (HOLDOFF > 0) ? 4'(HOLDOFF - 1) : 4'd0;
  localparam logic [5:0] ECODE_INT = 6'h00;
  // Ecodes indexed by wb_excp_vec bit: ADEF, INE, SYS, BRK, ALE
  localparam logic [5:0] VEC_ECODE [5] = '{6'h08, 6'h0D, 6'h0B, 6'h0C, 6'h09};

  state_t             state_reg, state_next;
  logic               excp_reg;
  logic [5:0]         ecode_reg;
  logic [31:0]        pc_reg;
  logic [31:0]        vaddr_reg;
  logic [31:0]        redirect_pc_reg;
  logic [3:0]         hold_cnt_reg;
  logic [COUNT_W-1:0] count_reg;

  logic               accept;
  logic               has_excp;
  logic               has_event;
  logic               handshake;
  logic [4:0]         vec_first;
  logic [5:0]         ecode_term [5];
  logic [5:0]         sel_ecode;
  logic [31:0]        sel_vaddr;

  // One-hot of the highest-priority (lowest index) exception bit.
  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_prio
      if (gi == 0) begin : g_first
        assign vec_first[gi] = bus.wb_excp_vec[0];
      end else begin : g_rest
        assign vec_first[gi] = bus.wb_excp_vec[gi] & ~(|bus.wb_excp_vec[gi-1:0]);
      end
      assign ecode_term[gi] = vec_first[gi] ? VEC_ECODE[gi] : 6'd0;
    end
  endgenerate

  assign has_excp  = bus.interrupt | (|bus.wb_excp_vec);
  assign has_event = has_excp | bus.wb_ertn;
  assign accept    = (state_reg == IDLE) && bus.wb_valid;
  assign handshake = (state_reg == REDIRECT) && bus.redirect_ready;

  always_comb begin
    sel_ecode = 6'd0;
    for (int i = 0; i < 5; i++) begin
      sel_ecode = sel_ecode | ecode_term[i];
    end
    if (bus.interrupt) begin
      sel_ecode = ECODE_INT;
    end
  end

  // BADV only carries an address for ADEF (fetch PC) and ALE (data address).
  always_comb begin
    sel_vaddr = 32'd0;
    if (!bus.interrupt) begin
      if (vec_first[0]) begin
        sel_vaddr = bus.wb_inst_pc;
      end else if (vec_first[4]) begin
        sel_vaddr = bus.wb_vaddr_in;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept && has_event) begin
          state_next = COMMIT;
        end
      end
      COMMIT: begin
        state_next = REDIRECT;
      end
      REDIRECT: begin
        if (bus.redirect_ready) begin
          state_next = (HOLDOFF > 0) ? HOLD : IDLE;
        end
      end
      HOLD: begin
        if (hold_cnt_reg == 4'd0) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      excp_reg        <= 1'b0;
      ecode_reg       <= 6'd0;
      pc_reg          <= 32'd0;
      vaddr_reg       <= 32'd0;
      redirect_pc_reg <= 32'd0;
      hold_cnt_reg    <= 4'd0;
      count_reg       <= '0;
    end else begin
      if (accept && has_event) begin
        excp_reg  <= has_excp;
        ecode_reg <= sel_ecode;
        pc_reg    <= bus.wb_inst_pc;
        vaddr_reg <= sel_vaddr;
      end
      if (state_reg == COMMIT) begin
        redirect_pc_reg <= excp_reg ? bus.exception_entry : bus.exception_return_entry;
        if (count_reg != {COUNT_W{1'b1}}) begin
          count_reg <= count_reg + 1'b1;
        end
      end
      if (handshake) begin
        hold_cnt_reg <= HOLD_LAST;
      end else if ((state_reg == HOLD) && (hold_cnt_reg != 4'd0)) begin
        hold_cnt_reg <= hold_cnt_reg - 4'd1;
      end
    end
  end

  // Ready is masked by rst so every output reads 0 while reset is held.
  always_comb begin
    bus.wb_ready       = (state_reg == IDLE) && !rst;
    bus.wb_exception   = (state_reg == COMMIT) && excp_reg;
    bus.ertn_flush     = (state_reg == COMMIT) && !excp_reg;
    bus.pipe_flush     = (state_reg == COMMIT) || (state_reg == REDIRECT);
    bus.redirect_valid = (state_reg == REDIRECT);
    bus.redirect_pc    = 32'd0;
    bus.wb_ecode       = 6'd0;
    bus.wb_esubcode    = 9'd0;
    bus.wb_pc          = 32'd0;
    bus.wb_vaddr       = 32'd0;
    bus.event_count    = count_reg;
    if (state_reg == REDIRECT) begin
      bus.redirect_pc = redirect_pc_reg;
    end
    if ((state_reg == COMMIT) && excp_reg) begin
      bus.wb_ecode = ecode_reg;
      bus.wb_pc    = pc_reg;
      bus.wb_vaddr = vaddr_reg;
    end
  end

endmodule

// File: tb/tb_excp_commit_ctrl.sv
// Directed bench for excp_commit_ctrl: a HOLDOFF=2/16-bit-counter unit and a
// HOLDOFF=0/2-bit-counter unit share the same stimulus.
module tb_excp_commit_ctrl;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  excp_commit_ctrl_if #(.COUNT_W(16)) bus ();
  excp_commit_ctrl_if #(.COUNT_W(2))  bus2 ();

  excp_commit_ctrl #(.HOLDOFF(2), .COUNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  excp_commit_ctrl #(.HOLDOFF(0), .COUNT_W(2))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

  assign bus2.wb_valid               = bus.wb_valid;
  assign bus2.wb_inst_pc             = bus.wb_inst_pc;
  assign bus2.wb_excp_vec            = bus.wb_excp_vec;
  assign bus2.wb_vaddr_in            = bus.wb_vaddr_in;
  assign bus2.wb_ertn                = bus.wb_ertn;
  assign bus2.interrupt              = bus.interrupt;
  assign bus2.exception_entry        = bus.exception_entry;
  assign bus2.exception_return_entry = bus.exception_return_entry;
  assign bus2.redirect_ready         = bus.redirect_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic [31:0] pc, input logic [4:0] vec, input logic ertn,
                         input logic irq, input logic [31:0] vaddr);
    bus.wb_valid    = 1'b1;
    bus.wb_inst_pc  = pc;
    bus.wb_excp_vec = vec;
    bus.wb_ertn     = ertn;
    bus.interrupt   = irq;
    bus.wb_vaddr_in = vaddr;
  endtask

  task automatic clear_wb();
    bus.wb_valid    = 1'b0;
    bus.wb_excp_vec = 5'd0;
    bus.wb_ertn     = 1'b0;
    bus.interrupt   = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    clear_wb();
    bus.wb_inst_pc             = 32'd0;
    bus.wb_vaddr_in            = 32'd0;
    bus.exception_entry        = 32'h1C00_8000;
    bus.exception_return_entry = 32'h0;
    bus.redirect_ready         = 1'b0;
    tick();
    chk("rst_ready", {31'd0, bus.wb_ready}, 32'd0);
    chk("rst_rvalid", {31'd0, bus.redirect_valid}, 32'd0);
    chk("rst_count", {16'd0, bus.event_count}, 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_ready", {31'd0, bus.wb_ready}, 32'd1);
    $display("reset released: wb_ready=%0b", bus.wb_ready);

    // SYS
    present(32'h1C00_0100, 5'b00100, 1'b0, 1'b0, 32'h0);
    chk("sys_ready_T", {31'd0, bus.wb_ready}, 32'd1);
    tick();
    clear_wb();
    chk("sys_exc", {31'd0, bus.wb_exception}, 32'd1);
    chk("sys_ecode", {26'd0, bus.wb_ecode}, 32'h0B);
    chk("sys_pc", bus.wb_pc, 32'h1C00_0100);
    chk("sys_vaddr", bus.wb_vaddr, 32'h0);
    chk("sys_ertn", {31'd0, bus.ertn_flush}, 32'd0);
    chk("sys_flush", {31'd0, bus.pipe_flush}, 32'd1);
    chk("sys_ready_T1", {31'd0, bus.wb_ready}, 32'd0);
    chk("sys_rvalid_T1", {31'd0, bus.redirect_valid}, 32'd0);
    bus.redirect_ready = 1'b1;
    tick();
    chk("sys_rvalid", {31'd0, bus.redirect_valid}, 32'd1);
    chk("sys_rpc", bus.redirect_pc, 32'h1C00_8000);
    chk("sys_exc_off", {31'd0, bus.wb_exception}, 32'd0);
    chk("sys_ecode_off", {26'd0, bus.wb_ecode}, 32'h0);
    chk("sys_count", {16'd0, bus.event_count}, 32'd1);
    chk("sys_count2", {30'd0, bus2.event_count}, 32'd1);
    tick();
    chk("sys_hold_ready", {31'd0, bus.wb_ready}, 32'd0);
    chk("sys_hold_flush", {31'd0, bus.pipe_flush}, 32'd0);
    chk("sys_h0_ready", {31'd0, bus2.wb_ready}, 32'd1);
    tick();
    chk("sys_hold2_ready", {31'd0, bus.wb_ready}, 32'd0);
    tick();
    chk("sys_idle_ready", {31'd0, bus.wb_ready}, 32'd1);
    $display("SYS commit done: count=%0d", bus.event_count);

    // ADEF + ALE on one instruction
    present(32'h1C00_0203, 5'b10001, 1'b0, 1'b0, 32'hDEAD_BEEF);
    tick();
    clear_wb();
    chk("adef_ecode", {26'd0, bus.wb_ecode}, 32'h08);
    chk("adef_vaddr", bus.wb_vaddr, 32'h1C00_0203);
    chk("adef_esub", {23'd0, bus.wb_esubcode}, 32'h0);
    tick();
    tick();
    tick();
    tick();
    chk("adef_idle", {31'd0, bus.wb_ready}, 32'd1);
    chk("adef_count", {16'd0, bus.event_count}, 32'd2);
    $display("ADEF+ALE commit done: count=%0d", bus.event_count);

    // interrupt together with ertn
    bus.exception_return_entry = 32'h1C00_0400;
    present(32'h1C00_0300, 5'b00000, 1'b1, 1'b1, 32'h0);
    tick();
    clear_wb();
    chk("int_exc", {31'd0, bus.wb_exception}, 32'd1);
    chk("int_ecode", {26'd0, bus.wb_ecode}, 32'h00);
    chk("int_ertn", {31'd0, bus.ertn_flush}, 32'd0);
    chk("int_pc", bus.wb_pc, 32'h1C00_0300);
    tick();
    chk("int_rpc", bus.redirect_pc, 32'h1C00_8000);
    tick();
    tick();
    tick();
    chk("int_count", {16'd0, bus.event_count}, 32'd3);
    chk("int_count2", {30'd0, bus2.event_count}, 32'd3);
    $display("INT commit done: count=%0d", bus.event_count);

    // ertn with a 3-cycle redirect stall
    bus.redirect_ready = 1'b0;
    present(32'h1C00_0500, 5'b00000, 1'b1, 1'b0, 32'h0);
    tick();
    clear_wb();
    chk("ertn_flush", {31'd0, bus.ertn_flush}, 32'd1);
    chk("ertn_exc", {31'd0, bus.wb_exception}, 32'd0);
    chk("ertn_wbpc", bus.wb_pc, 32'h0);
    tick();
    bus.exception_return_entry = 32'h1234_5678;
    chk("ertn_flush_off", {31'd0, bus.ertn_flush}, 32'd0);
    for (int c = 1; c <= 3; c++) begin
      chk($sformatf("ertn_rvalid_c%0d", c), {31'd0, bus.redirect_valid}, 32'd1);
      chk($sformatf("ertn_rpc_c%0d", c), bus.redirect_pc, 32'h1C00_0400);
      chk($sformatf("ertn_pflush_c%0d", c), {31'd0, bus.pipe_flush}, 32'd1);
      if (c == 3) bus.redirect_ready = 1'b1;
      tick();
    end
    chk("ertn_h1_ready", {31'd0, bus.wb_ready}, 32'd0);
    chk("ertn_h1_rvalid", {31'd0, bus.redirect_valid}, 32'd0);
    chk("ertn_h0_ready", {31'd0, bus2.wb_ready}, 32'd1);
    tick();
    chk("ertn_h2_ready", {31'd0, bus.wb_ready}, 32'd0);
    tick();
    chk("ertn_idle", {31'd0, bus.wb_ready}, 32'd1);
    chk("ertn_count", {16'd0, bus.event_count}, 32'd4);
    chk("ertn_count2", {30'd0, bus2.event_count}, 32'd3);
    $display("ERTN commit done: count=%0d", bus.event_count);

    // plain instruction retires silently
    present(32'h1C00_0600, 5'b00000, 1'b0, 1'b0, 32'h0);
    tick();
    clear_wb();
    chk("plain_ready", {31'd0, bus.wb_ready}, 32'd1);
    chk("plain_flush", {31'd0, bus.pipe_flush}, 32'd0);
    chk("plain_exc", {31'd0, bus.wb_exception}, 32'd0);
    $display("plain retire done: count=%0d", bus.event_count);

    // INE + BRK: INE wins
    present(32'h1C00_0700, 5'b01010, 1'b0, 1'b0, 32'h0);
    tick();
    clear_wb();
    chk("ine_ecode", {26'd0, bus.wb_ecode}, 32'h0D);
    tick();
    tick();
    tick();
    tick();
    chk("ine_count", {16'd0, bus.event_count}, 32'd5);
    chk("sat_count2", {30'd0, bus2.event_count}, 32'd3);
    $display("INE commit done: count=%0d count2=%0d", bus.event_count, bus2.event_count);

    // asynchronous reset while a redirect is pending
    bus.redirect_ready = 1'b0;
    present(32'h1C00_0100, 5'b00100, 1'b0, 1'b0, 32'h0);
    tick();
    clear_wb();
    tick();
    chk("pre_rst_rvalid", {31'd0, bus.redirect_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_rvalid", {31'd0, bus.redirect_valid}, 32'd0);
    chk("arst_flush", {31'd0, bus.pipe_flush}, 32'd0);
    chk("arst_count", {16'd0, bus.event_count}, 32'd0);
    rst = 1'b0;
    tick();
    chk("arst_ready", {31'd0, bus.wb_ready}, 32'd1);
    chk("arst_rvalid_after", {31'd0, bus.redirect_valid}, 32'd0);
    $display("async reset mid-redirect done: wb_ready=%0b", bus.wb_ready);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
